bs_loader: RTL

//  Upstream feeder for the neurochip configuration chain. Accepts config bytes

---
 rtl/bs_pkg.sv | 18 +
 rtl/bs_crc8.sv | 26 ++
 rtl/bs_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bs_pkg.sv
// Shared types, constants and the serial CRC-8 step used by the
// configuration-chain loader and its readback logic.
package bs_pkg;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} bs_state_t;

   localparam logic [7:0] CRC8_POLY         = 8'h07;
   localparam int         DEFAULT_CHAIN_LEN = 400;

   // One MSB-first CRC-8 step: shift left, fold the polynomial in when the
   // bit leaving the top differs from the incoming data bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic w_fb;
      w_fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/bs_crc8.sv
// Serial CRC-8 register (poly 0x07, init 0) with a synchronous clear and a
// per-bit enable; clear wins over enable.
module bs_crc8
   import bs_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_crc <= 8'h00;
      end else if (i_en) begin
         r_crc <= crc8_step(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/bs_loader.sv
// Feeds config bytes MSB-first into the neurochip configuration chain and
// computes a CRC-8 over the old chain contents that fall out of its tail.
module bs_loader
   import bs_pkg::*;
#(
   parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
   parameter int CNT_W     = 9
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       bs_out,
   output logic       cfg_bit,
   output logic       cfg_en,
   output logic       busy,
   output logic       done,
   output logic [7:0] rb_crc
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

   bs_state_t        r_state;
   logic [7:0]       r_shreg;
   logic [2:0]       r_bitIdx;
   logic [CNT_W-1:0] r_bitCnt;
   logic             r_cfgBit;
   logic             r_cfgEn;
   logic             r_busy;
   logic             r_done;

   logic w_lastBit;
   logic w_startOk;
   logic w_byteReady;
   logic w_take;

   // Ready is masked by abort/reset so a byte offered in that cycle is never
   // seen as accepted by the upstream side.
   assign w_lastBit   = (r_bitCnt == LAST_CNT);
   assign w_startOk   = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_byteReady = !reset && !abort &&
                        ((r_state == S_FETCH) ||
                         ((r_state == S_SHIFT) && (r_bitIdx == 3'd0) && !w_lastBit));
   assign w_take      = byte_valid && w_byteReady;

   // In DONE, busy drops and done rises together one cycle after the last bit
   // is presented, so the final readback CRC step has already landed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shreg  <= 8'h00;
         r_bitIdx <= 3'd0;
         r_bitCnt <= '0;
         r_cfgBit <= 1'b0;
         r_cfgEn  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else if (abort && (r_state != S_IDLE)) begin
         r_state <= S_IDLE;
         r_cfgEn <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_startOk) begin
                  r_state  <= S_FETCH;
                  r_bitCnt <= '0;
                  r_cfgEn  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end else if (r_state == S_DONE) begin
                  r_cfgEn <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_FETCH: begin
               r_cfgEn <= 1'b0;
               if (w_take) begin
                  r_shreg  <= byte_data;
                  r_bitIdx <= 3'd7;
                  r_state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_cfgEn  <= 1'b1;
               r_cfgBit <= r_shreg[r_bitIdx];
               r_bitCnt <= r_bitCnt + CNT_W'(1);
               r_bitIdx <= r_bitIdx - 3'd1;
               // Ending on the chain length drops any unused low bits of a partial byte.
               if (w_lastBit) begin
                  r_state <= S_DONE;
               end else if (r_bitIdx == 3'd0) begin
                  if (w_take) begin
                     r_shreg  <= byte_data;
                     r_bitIdx <= 3'd7;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   bs_crc8 u_crc (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_startOk),
      .i_en    (r_cfgEn),
      .i_bit   (bs_out),
      .o_crc   (rb_crc)
   );

   assign byte_ready = w_byteReady;
   assign cfg_bit    = r_cfgBit;
   assign cfg_en     = r_cfgEn;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule
